// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the ALU: register file, pending-writeback
// scoreboard, writeback bypass and a registered valid/ready operand bundle.
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [OPW-1:0]  in_alu_op,
    input  logic            in_wb_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] input1,
    output logic [XLEN-1:0] input2,
    output logic [OPW-1:0]  alu_op,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [32];
    logic [31:0]     pend;

    logic            wb_hit1;
    logic            wb_hit2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] operand2;
    logic            src1_busy;
    logic            src2_busy;
    logic            hazard;
    logic            accept;

    // x0 is never written, so regs[0] reads back 0 without a special case.
    always_comb begin
        wb_hit1   = wb_en && (wb_rd == in_rs1);
        wb_hit2   = wb_en && (wb_rd == in_rs2);
        op_a      = (wb_hit1 && in_rs1 != 5'd0) ? wb_data : regs[in_rs1];
        op_b      = (wb_hit2 && in_rs2 != 5'd0) ? wb_data : regs[in_rs2];
        operand2  = in_use_imm ? in_imm : op_b;
        src1_busy = pend[in_rs1] && !wb_hit1;
        src2_busy = !in_use_imm && pend[in_rs2] && !wb_hit2;
        hazard    = src1_busy || src2_busy;
        in_ready  = (!out_valid || out_ready) && !hazard;
        accept    = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // The set is applied after the clear so a newly issued writer keeps ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            if (wb_en) begin
                pend[wb_rd] <= 1'b0;
            end
            if (accept && in_wb_en && in_rd != 5'd0) begin
                pend[in_rd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            input1    <= '0;
            input2    <= '0;
            alu_op    <= '0;
            out_rd    <= '0;
            out_wb_en <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            input1    <= op_a;
            input2    <= operand2;
            alu_op    <= in_alu_op;
            out_rd    <= in_rd;
            out_wb_en <= in_wb_en;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, bypass, hazards, backpressure,
// same-cycle scoreboard set/clear and mid-operation reset.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_alu_op;
    logic        in_wb_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [4:0]  alu_op;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    alu_operand_stage #(.XLEN(32), .OPW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_alu_op(in_alu_op), .in_wb_en(in_wb_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .input1(input1), .input2(input2), .alu_op(alu_op),
        .out_rd(out_rd), .out_wb_en(out_wb_en),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] imm, input logic ui,
                                 input logic [4:0] op, input logic wbe);
        in_valid   = v;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_imm     = imm;
        in_use_imm = ui;
        in_alu_op  = op;
        in_wb_en   = wbe;
    endtask

    task automatic writeback(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_en   = en;
        wb_rd   = rd;
        wb_data = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        writeback(1'b0, 5'd0, 32'h0);

        // Reset values and first accept
        step();
        step();
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("rst_input1", input1, 32'h0);
        checkOutput("rst_input2", input2, 32'h0);
        checkOutput("rst_alu_op", {27'b0, alu_op}, 32'h0);
        checkOutput("rst_out_rd", {27'b0, out_rd}, 32'h0);
        checkOutput("rst_out_wb_en", {31'b0, out_wb_en}, 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd0, 32'h10, 1'b1, 5'd3, 1'b0);
        #1;
        checkOutput("t1_in_ready", {31'b0, in_ready}, 32'h1);
        step();
        checkOutput("t1_out_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("t1_input1", input1, 32'h0);
        checkOutput("t1_input2", input2, 32'h10);
        checkOutput("t1_alu_op", {27'b0, alu_op}, 32'h3);

        // Register write then read, plus x0 behaviour
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        writeback(1'b1, 5'd3, 32'hDEADBEEF);
        step();
        checkOutput("t2_drain_valid", {31'b0, out_valid}, 32'h0);
        writeback(1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd0, 32'h0, 1'b0, 5'd1, 1'b0);
        step();
        checkOutput("t2_input1_x3", input1, 32'hDEADBEEF);
        checkOutput("t2_input2_x3", input2, 32'hDEADBEEF);
        writeback(1'b1, 5'd0, 32'h55);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd1, 1'b0);
        step();
        checkOutput("t2_x0_nobypass", input1, 32'h0);
        writeback(1'b0, 5'd0, 32'h0);
        step();
        checkOutput("t2_x0_read1", input1, 32'h0);
        checkOutput("t2_x0_read2", input2, 32'h0);

        // RAW hazard on x7 resolved by writeback bypass
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 32'h1, 1'b1, 5'd2, 1'b1);
        step();
        applyStimulus(1'b1, 5'd7, 5'd0, 5'd8, 32'h2, 1'b1, 5'd4, 1'b0);
        #1;
        checkOutput("t3_stall_a", {31'b0, in_ready}, 32'h0);
        step();
        checkOutput("t3_drained", {31'b0, out_valid}, 32'h0);
        checkOutput("t3_stall_b", {31'b0, in_ready}, 32'h0);
        step();
        checkOutput("t3_stall_c", {31'b0, in_ready}, 32'h0);
        writeback(1'b1, 5'd7, 32'h1234);
        #1;
        checkOutput("t3_wb_ready", {31'b0, in_ready}, 32'h1);
        step();
        writeback(1'b0, 5'd0, 32'h0);
        checkOutput("t3_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("t3_bypass", input1, 32'h1234);
        checkOutput("t3_imm", input2, 32'h2);
        checkOutput("t3_rd", {27'b0, out_rd}, 32'h8);
        applyStimulus(1'b1, 5'd7, 5'd0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        #1;
        checkOutput("t3_cleared_ready", {31'b0, in_ready}, 32'h1);
        step();
        checkOutput("t3_regfile_x7", input1, 32'h1234);

        // Backpressure holds the bundle, then a back-to-back transfer
        applyStimulus(1'b1, 5'd3, 5'd0, 5'd10, 32'hA5, 1'b1, 5'd7, 1'b0);
        step();
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd11, 32'hB6, 1'b1, 5'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t4_bp_ready", {31'b0, in_ready}, 32'h0);
            step();
            checkOutput("t4_bp_valid", {31'b0, out_valid}, 32'h1);
            checkOutput("t4_bp_input1", input1, 32'hDEADBEEF);
            checkOutput("t4_bp_input2", input2, 32'hA5);
            checkOutput("t4_bp_op", {27'b0, alu_op}, 32'h7);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("t4_release_ready", {31'b0, in_ready}, 32'h1);
        step();
        checkOutput("t4_b2b_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("t4_b2b_input2", input2, 32'hB6);
        checkOutput("t4_b2b_op", {27'b0, alu_op}, 32'h9);
        checkOutput("t4_b2b_rd", {27'b0, out_rd}, 32'hB);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        step();
        checkOutput("t4_idle_valid", {31'b0, out_valid}, 32'h0);

        // Same-cycle accept and writeback on x9: the set wins
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 1'b1, 5'd5, 1'b1);
        writeback(1'b1, 5'd9, 32'h99);
        step();
        writeback(1'b0, 5'd0, 32'h0);
        checkOutput("t5_wb_flag", {31'b0, out_wb_en}, 32'h1);
        applyStimulus(1'b1, 5'd9, 5'd0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0);
        #1;
        checkOutput("t5_stall_a", {31'b0, in_ready}, 32'h0);
        step();
        checkOutput("t5_stall_b", {31'b0, in_ready}, 32'h0);
        writeback(1'b1, 5'd9, 32'h777);
        #1;
        checkOutput("t5_wb_ready", {31'b0, in_ready}, 32'h1);
        step();
        writeback(1'b0, 5'd0, 32'h0);
        checkOutput("t5_bypass", input1, 32'h777);

        // Reset while a bundle is held and x4 is pending
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 32'h3C, 1'b1, 5'd8, 1'b1);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        checkOutput("t6_pre_valid", {31'b0, out_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("t6_async_input2", input2, 32'h0);
        step();
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd4, 5'd4, 5'd0, 32'h0, 1'b0, 5'd1, 1'b0);
        #1;
        checkOutput("t6_x4_ready", {31'b0, in_ready}, 32'h1);
        step();
        checkOutput("t6_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("t6_input1", input1, 32'h0);
        checkOutput("t6_input2", input2, 32'h0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the ALU. It contains the 32-entry integer register file and accepts one decoded instruction per cycle over a valid/ready handshake.
- It reads rs1/rs2, muxes the immediate into operand 2, and presents a registered input1/input2/alu_op bundle to the ALU.
- A per-register pending scoreboard stalls instructions whose source registers still await ALU writeback. A writeback-to-read bypass covers the same-cycle case.

Parameters:
XLEN, 32, datapath width of registers, immediates and operands
OPW, 5, width of the ALU operation code (matches the ALU's 5-bit alu_op)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoder presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_rs1  in  5  source register 1 index
in_rs2  in  5  source register 2 index (ignored when in_use_imm=1)
in_rd  in  5  destination register index
in_imm  in  XLEN  sign-extended immediate from the decoder
in_use_imm  in  1  1 selects in_imm as operand 2, 0 selects rs2
in_alu_op  in  OPW  ALU operation code
in_wb_en  in  1  instruction writes rd
out_valid  out  1  ALU operand bundle valid
out_ready  in  1  ALU side consumes the bundle
input1  out  XLEN  operand 1 to the ALU
input2  out  XLEN  operand 2 to the ALU
alu_op  out  OPW  operation code to the ALU
out_rd  out  5  destination index travelling with the bundle
out_wb_en  out  1  writeback flag travelling with the bundle
wb_en  in  1  writeback strobe for the ALU result
wb_rd  in  5  writeback register index
wb_data  in  XLEN  writeback value (registered alu_result)

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset state:
  - All 32 registers = 0; all pending bits = 0.
  - out_valid=0; input1, input2, alu_op, out_rd, out_wb_en = 0.
  - Reset mid-operation discards the held bundle and all pending state immediately.
- x0 handling: reads always return 0; writes to x0 are ignored; x0 is never marked pending.
- Register file writes: when wb_en=1, regs[wb_rd] <= wb_data on the clock edge.
- Operand read and bypass (combinational):
  - opA = (wb_en && wb_rd==in_rs1 && in_rs1!=0) ? wb_data : regs[in_rs1].
  - opB is formed the same way for in_rs2.
  - Operand 2 = in_use_imm ? in_imm : opB.
- Hazard (combinational):
  - src1_busy = pend[in_rs1] && !(wb_en && wb_rd==in_rs1).
  - src2_busy = !in_use_imm && pend[in_rs2] && !(wb_en && wb_rd==in_rs2).
  - hazard = src1_busy || src2_busy.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard. in_ready does not depend on in_valid.
  - accept = in_valid && in_ready. On accept, the output registers load input1, input2, alu_op, out_rd and out_wb_en, and out_valid <= 1.
  - If out_valid && out_ready && !accept, then out_valid <= 0.
  - While out_valid && !out_ready, all outputs hold stable.
  - Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction per cycle when there are no hazards.
- Scoreboard:
  - On accept with in_wb_en && in_rd!=0: pend[in_rd] <= 1.
  - On wb_en: pend[wb_rd] <= 0.
  - If both events target the same register in the same cycle, the set wins (the newer instruction owns the register).
  - Pending bits are cleared only by writeback, never by out_ready.
- Writeback with no pending bit: the write still updates the register file, and the scoreboard is unchanged.
- Self-dependence (rd == rs1): resolved correctly. The hazard check uses the pre-accept pending state, and the pend set applies at the edge.
- Arithmetic: none in this stage. All values pass through at XLEN bits without modification.

Test Plan:
1. Reset with rst_n=0, then release; read rs1=5 with in_use_imm=1, imm=0x10 -> next cycle out_valid=1, input1=0, input2=0x10; all outputs were 0 during reset.
2. wb_en writes x3=0xDEADBEEF; the following cycle issue rs1=3, rs2=3, in_use_imm=0 -> input1=input2=0xDEADBEEF. Also issue wb_rd=0 with data 0x55 and then read x0 -> 0.
3. Issue I1 with rd=7 and wb_en; next cycle issue I2 with rs1=7 -> in_ready=0 until wb_en, wb_rd=7, wb_data=0x1234 arrives. In the wb cycle in_ready=1 and input1=0x1234 (bypass).
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0. Then set out_ready=1 with a new in_valid -> back-to-back transfer and out_valid stays 1.
5. Same-cycle event: accept an instruction with rd=9 while wb_en, wb_rd=9 -> pend[9]=1 afterwards, and a subsequent reader of x9 stalls until the next x9 writeback.
6. Assert rst_n low while out_valid=1 and pend[4]=1 -> out_valid=0 asynchronously; after release, a reader of x4 is not stalled and reads 0.
